// File: rtl/bus_ram_slave.sv
// rtl/bus_ram_slave.sv - request/ack RAM slave with programmable read latency
module bus_ram_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rwn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]      CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_oor;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic             w_accept;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;

  assign w_accept   = (r_state == IDLE) && req;
  assign w_in_range = ({1'b0, addr} < DEPTH_V);
  assign w_idx      = addr[IDX_W-1:0];

  // Memory has no reset; a write commits on the acceptance edge itself.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && !rwn && w_in_range) begin
      r_mem[w_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_idx <= w_idx;
            r_oor <= !w_in_range;
            busy  <= 1'b1;
            if (rwn && (RD_LAT > 1)) begin
              r_state <= RD_WAIT;
              r_cnt   <= CNT_INIT;
            end else begin
              r_state <= ACK;
              ack     <= 1'b1;
              err     <= !w_in_range;
              if (rwn && w_in_range) begin
                rdata <= r_mem[w_idx];
              end
            end
          end
        end
        RD_WAIT: begin
          // Outputs are loaded on the edge entering ACK so ack/err/rdata stay registered.
          if (r_cnt == 2'd1) begin
            r_state <= ACK;
            r_cnt   <= '0;
            ack     <= 1'b1;
            err     <= r_oor;
            if (!r_oor) begin
              rdata <= r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ACK: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ram_slave.sv
// tb/tb_bus_ram_slave.sv - randomized self-checking bench for bus_ram_slave
module tb_bus_ram_slave;

  localparam int DEP [3] = '{256, 8, 256};
  localparam int LAT [3] = '{1, 3, 4};

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic       req   [3];
  logic       rwn   [3];
  logic [7:0] addr  [3];
  logic [7:0] wdata [3];
  logic       ack   [3];
  logic [7:0] rdata [3];
  logic       err   [3];
  logic       busy  [3];

  logic [7:0] m_mem [3][256];
  bit         m_vld [3][256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_ram_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .rwn(rwn[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]));
  bus_ram_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(8), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .rwn(rwn[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]));
  bus_ram_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .rwn(rwn[2]), .addr(addr[2]), .wdata(wdata[2]),
    .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2]));

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One transaction from the requester's view; called at a negedge.
  task automatic txn(input int k, input bit rd, input logic [7:0] a, input logic [7:0] d,
                     input string tag);
    bit         was_busy;
    bit         got;
    int         cyc;
    int         acc;
    int         exp_lat;
    bit         exp_err;
    logic [7:0] exp_rd;
    exp_err = (int'(a) >= DEP[k]);
    exp_rd  = (rd && !exp_err) ? m_mem[k][a] : 8'h00;
    if (!rd && !exp_err) begin
      m_mem[k][a] = d;
      m_vld[k][a] = 1'b1;
    end
    was_busy = (busy[k] === 1'b1);
    acc      = was_busy ? 1 : 0;
    exp_lat  = (rd ? LAT[k] : 1) + acc;
    req[k] = 1'b1; rwn[k] = rd; addr[k] = a; wdata[k] = d;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (was_busy && cyc == 1) begin
        n_checks++;
        if (busy[k] !== 1'b0) begin
          n_errors++;
          $display("FAIL %s idle_gap k=%0d: busy=%b required 0", tag, k, busy[k]);
        end
      end
      if (cyc > acc) begin
        n_checks++;
        if (busy[k] !== 1'b1) begin
          n_errors++;
          $display("FAIL %s busy k=%0d cyc=%0d: busy=%b required 1", tag, k, cyc, busy[k]);
        end
      end
      if (ack[k] === 1'b1) begin
        got = 1'b1;
      end else begin
        n_checks++;
        if (err[k] !== 1'b0 || rdata[k] !== 8'h00) begin
          n_errors++;
          $display("FAIL %s quiet k=%0d cyc=%0d: err=%b rdata=%h required 0/00", tag, k, cyc,
                   err[k], rdata[k]);
        end
      end
    end
    req[k] = 1'b0;
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL %s timeout k=%0d: no ack within %0d cycles", tag, k, cyc);
    end else if (cyc != exp_lat || err[k] !== exp_err || rdata[k] !== exp_rd) begin
      n_errors++;
      $display("FAIL %s ack k=%0d a=%h: lat=%0d err=%b rdata=%h required lat=%0d err=%b rdata=%h",
               tag, k, a, cyc, err[k], rdata[k], exp_lat, exp_err, exp_rd);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b1; rwn[k] = 1'b1; addr[k] = 8'h00; wdata[k] = 8'h00;
    end
    idle(3);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 8'h00 || busy[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset k=%0d: ack=%b err=%b rdata=%h busy=%b required all 0", k, ack[k],
                 err[k], rdata[k], busy[k]);
      end
      req[k]   = 1'b0;
      rst_n[k] = 1'b1;
    end
    idle(1);
  endtask

  task automatic test_write_read();
    txn(0, 1'b0, 8'h05, 8'hA5, "wr_rd_write");
    idle(2);
    txn(0, 1'b1, 8'h05, 8'h00, "wr_rd_read");
    idle(1);
  endtask

  task automatic test_latency();
    txn(1, 1'b0, 8'h03, 8'h3C, "lat_write");
    idle(2);
    txn(1, 1'b1, 8'h03, 8'h00, "lat_read");
    idle(1);
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 8; i++) txn(1, 1'b0, 8'(i), 8'($urandom), "oor_fill");
    txn(1, 1'b0, 8'h09, 8'hFF, "oor_write");
    txn(1, 1'b1, 8'h09, 8'h00, "oor_read");
    for (int i = 0; i < 8; i++) txn(1, 1'b1, 8'(i), 8'h00, "oor_readback");
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      txn(0, 1'b0, a, 8'($urandom), "b2b_write");
      txn(0, 1'b1, a, 8'h00, "b2b_read");
    end
    idle(1);
  endtask

  task automatic test_random(input int k, input int n, input int amax);
    logic [7:0] a;
    bit         rd;
    for (int i = 0; i < n; i++) begin
      a  = 8'($urandom_range(amax, 0));
      rd = ($urandom_range(1, 0) == 1) && (m_vld[k][a] || int'(a) >= DEP[k]);
      txn(k, rd, a, 8'($urandom), "random");
      idle($urandom_range(2, 0));
    end
    idle(1);
  endtask

  task automatic test_reset_mid_read();
    txn(2, 1'b0, 8'h40, 8'h96, "rst_prep");
    idle(1);
    req[2] = 1'b1; rwn[2] = 1'b1; addr[2] = 8'h40;
    idle(2);
    rst_n[2] = 1'b0;
    req[2]   = 1'b0;
    idle(1);
    n_checks++;
    if (ack[2] !== 1'b0 || busy[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_read: ack=%b busy=%b required 0/0", ack[2], busy[2]);
    end
    rst_n[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      n_checks++;
      if (ack[2] !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_no_late_ack cyc=%0d: ack=%b required 0", i, ack[2]);
      end
    end
    txn(2, 1'b1, 8'h40, 8'h00, "rst_after_read");
    idle(1);
    // reset landing while ack is showing
    req[0] = 1'b1; rwn[0] = 1'b1; addr[0] = 8'h05;
    idle(1);
    n_checks++;
    if (ack[0] !== 1'b1 || rdata[0] !== m_mem[0][5]) begin
      n_errors++;
      $display("FAIL rst_ack_pre: ack=%b rdata=%h required 1/%h", ack[0], rdata[0], m_mem[0][5]);
    end
    req[0]   = 1'b0;
    rst_n[0] = 1'b0;
    idle(1);
    n_checks++;
    if (ack[0] !== 1'b0 || busy[0] !== 1'b0 || rdata[0] !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_in_ack: ack=%b busy=%b rdata=%h required 0/0/00", ack[0], busy[0],
               rdata[0]);
    end
    rst_n[0] = 1'b1;
    idle(1);
  endtask

  task automatic test_early_drop();
    int         cyc;
    logic [7:0] d;
    d = 8'($urandom);
    req[2] = 1'b1; rwn[2] = 1'b0; addr[2] = 8'h77; wdata[2] = d;
    m_mem[2][8'h77] = d;
    m_vld[2][8'h77] = 1'b1;
    idle(1);
    req[2] = 1'b0;
    n_checks++;
    if (ack[2] !== 1'b1 || err[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL early_drop_write: ack=%b err=%b required 1/0", ack[2], err[2]);
    end
    idle(1);
    req[2] = 1'b1; rwn[2] = 1'b1; addr[2] = 8'h77;
    idle(1);
    req[2] = 1'b0;
    addr[2] = 8'h00;
    cyc = 1;
    while (ack[2] !== 1'b1 && cyc < 20) begin
      idle(1);
      cyc++;
    end
    n_checks++;
    if (ack[2] !== 1'b1 || cyc != LAT[2] || rdata[2] !== d) begin
      n_errors++;
      $display("FAIL early_drop_read: ack=%b lat=%0d rdata=%h required 1/%0d/%h", ack[2], cyc,
               rdata[2], LAT[2], d);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_out_of_range();
    test_back_to_back();
    test_random(0, 30, 255);
    test_random(1, 20, 15);
    test_random(2, 20, 255);
    test_reset_mid_read();
    test_early_drop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
